// File: rtl/uart_vram_loader.sv
// ----------------------------------------------------------------------------
// uart_vram_loader
//   Receives framed packets over a UART 8N1 line and turns every payload byte
//   into a single-cycle write strobe on the CPU-side port of the charmap or
//   chardata RAM.
//   Packet: A5, CMD, ADDR_HI, ADDR_LO, LEN, DATA x N (LEN=0 -> 256), CSUM.
//   CSUM is the XOR of CMD, ADDR_HI, ADDR_LO, LEN and all DATA bytes.
//
// Ports
//   clk        system / memory clock
//   rst        synchronous active-high reset
//   ftdi_rx    asynchronous UART receive line, idle high
//   address    write address (memories use [9:0])
//   data_w     write data
//   charmap_we one-cycle write strobe for charmap (CMD 0x01)
//   chardat_we one-cycle write strobe for chardata (CMD 0x02)
//   busy       a packet is in progress
//   err        sticky error: framing, bad command, bad checksum or timeout;
//              cleared by the next accepted 0xA5 or by rst
// ----------------------------------------------------------------------------
module uart_vram_loader #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 115200,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ftdi_rx,
    output logic [15:0] address,
    output logic [7:0]  data_w,
    output logic        charmap_we,
    output logic        chardat_we,
    output logic        busy,
    output logic        err
);

    localparam int DIV    = CLK_FREQ / BAUD;
    localparam int HALF   = DIV / 2;
    localparam int CW     = $clog2(DIV);
    localparam int TO_CYC = TIMEOUT_BITS * DIV;
    localparam int TW     = $clog2(TO_CYC + 1);

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t       r_rx_state, w_rx_state_next;
    logic [1:0]      r_rx_sync;
    logic [CW-1:0]   r_rx_cnt, w_rx_cnt_next;
    logic [2:0]      r_rx_bitn, w_rx_bitn_next;
    logic [7:0]      r_rx_shift, w_rx_shift_next;
    logic            r_rx_valid, w_rx_valid_next;
    logic            r_frame_err, w_frame_err_next;
    logic            w_rx;

    assign w_rx = r_rx_sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_sync   <= 2'b11;
            r_rx_state  <= RX_IDLE;
            r_rx_cnt    <= '0;
            r_rx_bitn   <= '0;
            r_rx_shift  <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_sync   <= {r_rx_sync[0], ftdi_rx};
            r_rx_state  <= w_rx_state_next;
            r_rx_cnt    <= w_rx_cnt_next;
            r_rx_bitn   <= w_rx_bitn_next;
            r_rx_shift  <= w_rx_shift_next;
            r_rx_valid  <= w_rx_valid_next;
            r_frame_err <= w_frame_err_next;
        end
    end

    always_comb begin
        w_rx_state_next  = r_rx_state;
        w_rx_cnt_next    = r_rx_cnt + CW'(1);
        w_rx_bitn_next   = r_rx_bitn;
        w_rx_shift_next  = r_rx_shift;
        w_rx_valid_next  = 1'b0;
        w_frame_err_next = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                w_rx_cnt_next = '0;
                if (!w_rx) w_rx_state_next = RX_START;
            end
            RX_START: begin
                // Mid-start re-sample: a high line here was only a glitch.
                if (r_rx_cnt == CW'(HALF - 1)) begin
                    w_rx_cnt_next   = '0;
                    w_rx_bitn_next  = '0;
                    w_rx_state_next = w_rx ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_rx_cnt == CW'(DIV - 1)) begin
                    w_rx_cnt_next   = '0;
                    w_rx_shift_next = {w_rx, r_rx_shift[7:1]};
                    w_rx_bitn_next  = r_rx_bitn + 3'd1;
                    if (r_rx_bitn == 3'd7) w_rx_state_next = RX_STOP;
                end
            end
            default: begin
                if (r_rx_cnt == CW'(DIV - 1)) begin
                    w_rx_state_next  = RX_IDLE;
                    w_rx_valid_next  = w_rx;
                    w_frame_err_next = !w_rx;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Packet FSM and write port
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {P_SYNC, P_CMD, P_AHI, P_ALO, P_LEN, P_DATA, P_CSUM} pk_state_t;

    pk_state_t     r_state, w_state_next;
    logic          r_sel, w_sel_next;          // 0 = charmap, 1 = chardata
    logic [15:0]   r_addr, w_addr_next;
    logic [8:0]    r_len, w_len_next;          // bytes still to write, 1..256
    logic [7:0]    r_csum, w_csum_next;
    logic [7:0]    r_data_w, w_data_next;
    logic          r_map_we, w_map_we_next;
    logic          r_dat_we, w_dat_we_next;
    logic          r_err, w_err_next;
    logic [TW-1:0] r_to_cnt;
    logic          w_timeout;

    assign w_timeout = (r_state != P_SYNC) && !r_rx_valid && (r_to_cnt == TW'(TO_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= P_SYNC;
            r_sel    <= 1'b0;
            r_addr   <= '0;
            r_len    <= '0;
            r_csum   <= '0;
            r_data_w <= '0;
            r_map_we <= 1'b0;
            r_dat_we <= 1'b0;
            r_err    <= 1'b0;
            r_to_cnt <= '0;
        end else begin
            r_state  <= w_state_next;
            r_sel    <= w_sel_next;
            r_addr   <= w_addr_next;
            r_len    <= w_len_next;
            r_csum   <= w_csum_next;
            r_data_w <= w_data_next;
            r_map_we <= w_map_we_next;
            r_dat_we <= w_dat_we_next;
            r_err    <= w_err_next;
            r_to_cnt <= (r_state == P_SYNC || r_rx_valid) ? '0 : r_to_cnt + TW'(1);
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_sel_next    = r_sel;
        w_addr_next   = r_addr;
        w_len_next    = r_len;
        w_csum_next   = r_csum;
        w_data_next   = r_data_w;
        w_map_we_next = 1'b0;
        w_dat_we_next = 1'b0;
        w_err_next    = r_err;

        // Address/count advance on the cycle after each strobe, so the
        // strobe cycle itself presents the target address.
        if (r_map_we || r_dat_we) begin
            w_addr_next = r_addr + 16'd1;
            w_len_next  = r_len - 9'd1;
        end

        if (r_rx_valid) begin
            case (r_state)
                P_SYNC: begin
                    if (r_rx_shift == 8'hA5) begin
                        w_state_next = P_CMD;
                        w_err_next   = 1'b0;
                        w_csum_next  = '0;
                    end
                end
                P_CMD: begin
                    w_csum_next = r_csum ^ r_rx_shift;
                    if (r_rx_shift == 8'h01 || r_rx_shift == 8'h02) begin
                        w_sel_next   = r_rx_shift[1];
                        w_state_next = P_AHI;
                    end else begin
                        w_err_next   = 1'b1;
                        w_state_next = P_SYNC;
                    end
                end
                P_AHI: begin
                    w_csum_next       = r_csum ^ r_rx_shift;
                    w_addr_next[15:8] = r_rx_shift;
                    w_state_next      = P_ALO;
                end
                P_ALO: begin
                    w_csum_next      = r_csum ^ r_rx_shift;
                    w_addr_next[7:0] = r_rx_shift;
                    w_state_next     = P_LEN;
                end
                P_LEN: begin
                    w_csum_next  = r_csum ^ r_rx_shift;
                    w_len_next   = (r_rx_shift == 8'h00) ? 9'd256 : {1'b0, r_rx_shift};
                    w_state_next = P_DATA;
                end
                P_DATA: begin
                    w_csum_next   = r_csum ^ r_rx_shift;
                    w_data_next   = r_rx_shift;
                    w_map_we_next = !r_sel;
                    w_dat_we_next = r_sel;
                    if (r_len == 9'd1) w_state_next = P_CSUM;
                end
                default: begin
                    if (r_rx_shift != r_csum) w_err_next = 1'b1;
                    w_state_next = P_SYNC;
                end
            endcase
        end

        if (r_frame_err || w_timeout) begin
            w_state_next = P_SYNC;
            w_err_next   = 1'b1;
        end
    end

    assign address    = r_addr;
    assign data_w     = r_data_w;
    assign charmap_we = r_map_we;
    assign chardat_we = r_dat_we;
    assign busy       = (r_state != P_SYNC);
    assign err        = r_err;

endmodule

// File: tb/tb_uart_vram_loader.sv
// ----------------------------------------------------------------------------
// tb_uart_vram_loader
//   Drives UART packets into uart_vram_loader (DIV = 10) and checks every write
//   strobe against a queue of expected writes derived from the packet contents,
//   plus err/busy at packet boundaries and hand-computed literal writes.
// ----------------------------------------------------------------------------
module tb_uart_vram_loader;

    localparam int CLK_FREQ = 50000000;
    localparam int BAUD     = 5000000;
    localparam int DIV      = CLK_FREQ / BAUD;
    localparam int TOB      = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ftdi_rx = 1'b1;
    logic [15:0] address;
    logic [7:0]  data_w;
    logic        charmap_we;
    logic        chardat_we;
    logic        busy;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [24:0] exp_q[$];     // {address, data, is_chardata}
    logic [15:0] obs_addr[$];
    logic [7:0]  obs_data[$];
    logic        obs_sel[$];

    uart_vram_loader #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD(BAUD),
        .TIMEOUT_BITS(TOB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ftdi_rx(ftdi_rx),
        .address(address),
        .data_w(data_w),
        .charmap_we(charmap_we),
        .chardat_we(chardat_we),
        .busy(busy),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] obs_a(input int idx);
        return (idx < obs_addr.size()) ? {16'h0, obs_addr[idx]} : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] obs_d(input int idx);
        return (idx < obs_data.size()) ? {24'h0, obs_data[idx]} : 32'hDEAD_BEEF;
    endfunction

    // Scoreboard: every strobe must match the oldest expected write.
    initial begin
        logic [24:0] e;
        forever begin
            @(negedge clk);
            if (charmap_we || chardat_we) begin
                check("one_we_only", {31'h0, charmap_we & chardat_we}, 32'h0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr 0x%04h data 0x%02h, expected no write",
                             address, data_w);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", {16'h0, address}, {16'h0, e[24:9]});
                    check("wr_data", {24'h0, data_w}, {24'h0, e[8:1]});
                    check("wr_sel", {31'h0, chardat_we}, {31'h0, e[0]});
                end
                obs_addr.push_back(address);
                obs_data.push_back(data_w);
                obs_sel.push_back(chardat_we);
                $display("write %s addr=0x%04h data=0x%02h",
                         chardat_we ? "chardata" : "charmap ", address, data_w);
            end
        end
    end

    task automatic idle_bits(input int n);
        repeat (n * DIV) @(negedge clk);
    endtask

    // Called and returns at a negedge.
    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        ftdi_rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            ftdi_rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        ftdi_rx = stop_ok;
        repeat (DIV) @(negedge clk);
        ftdi_rx = 1'b1;
        repeat (stop_ok ? DIV : 3 * DIV) @(negedge clk);
    endtask

    // Sends one packet and queues the writes it must cause.
    // bad_idx: data byte sent with a 0 stop bit; rst_idx: rst pulsed before that byte.
    task automatic send_packet(input string name, input logic [7:0] cmd, input logic [15:0] addr,
                               input logic [7:0] len, input logic [7:0] base, input bit bad_csum,
                               input int bad_idx, input int rst_idx, input bit exp_err);
        logic [7:0]  cs;
        logic [7:0]  d;
        logic [15:0] a;
        int          n;
        bit          live;
        n    = (len == 8'h00) ? 256 : int'(len);
        a    = addr;
        live = (cmd == 8'h01 || cmd == 8'h02);
        cs   = cmd ^ addr[15:8] ^ addr[7:0] ^ len;
        $display("packet %s cmd=%02h addr=%04h len=%02h", name, cmd, addr, len);
        send_byte(8'hA5, 1'b1);
        check({name, "_a5_err"}, {31'h0, err}, 32'h0);
        check({name, "_a5_busy"}, {31'h0, busy}, 32'h1);
        send_byte(cmd, 1'b1);
        send_byte(addr[15:8], 1'b1);
        send_byte(addr[7:0], 1'b1);
        send_byte(len, 1'b1);
        for (int i = 0; i < n; i++) begin
            d  = base + 8'(i);
            cs = cs ^ d;
            if (i == rst_idx) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                live = 1'b0;
                check("rst_address", {16'h0, address}, 32'h0);
                check("rst_data_w", {24'h0, data_w}, 32'h0);
                check("rst_we", {30'h0, charmap_we, chardat_we}, 32'h0);
                check("rst_busy_err", {30'h0, busy, err}, 32'h0);
            end
            if (live && i != bad_idx) exp_q.push_back({a, d, cmd == 8'h02});
            send_byte(d, i != bad_idx);
            if (i == bad_idx) begin
                live = 1'b0;
                check({name, "_ferr_err"}, {31'h0, err}, 32'h1);
                check({name, "_ferr_busy"}, {31'h0, busy}, 32'h0);
            end
            a = a + 16'd1;
        end
        send_byte(bad_csum ? ~cs : cs, 1'b1);
        idle_bits(2);
        check({name, "_end_err"}, {31'h0, err}, {31'h0, exp_err});
        check({name, "_end_busy"}, {31'h0, busy}, 32'h0);
        check({name, "_pending"}, exp_q.size(), 32'h0);
    endtask

    initial begin
        int n0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_address", {16'h0, address}, 32'h0);
        check("reset_data_w", {24'h0, data_w}, 32'h0);
        check("reset_charmap_we", {31'h0, charmap_we}, 32'h0);
        check("reset_chardat_we", {31'h0, chardat_we}, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_err", {31'h0, err}, 32'h0);
        idle_bits(2);

        // Basic charmap packet.
        n0 = obs_addr.size();
        send_packet("A", 8'h01, 16'h0010, 8'h03, 8'h41, 1'b0, -1, -1, 1'b0);
        check("A_count", obs_addr.size() - n0, 32'd3);
        check("A_w0_addr", obs_a(n0), 32'h0010);
        check("A_w1_addr", obs_a(n0 + 1), 32'h0011);
        check("A_w2_addr", obs_a(n0 + 2), 32'h0012);
        check("A_w0_data", obs_d(n0), 32'h41);
        check("A_w2_data", obs_d(n0 + 2), 32'h43);

        // chardata with a wrong checksum: writes stay, err set.
        n0 = obs_addr.size();
        send_packet("B", 8'h02, 16'h0010, 8'h03, 8'h41, 1'b1, -1, -1, 1'b1);
        check("B_count", obs_addr.size() - n0, 32'd3);

        // Address wrap; its 0xA5 also clears err left by B.
        n0 = obs_addr.size();
        send_packet("C", 8'h01, 16'hFFFF, 8'h02, 8'h55, 1'b0, -1, -1, 1'b0);
        check("C_w0_addr", obs_a(n0), 32'hFFFF);
        check("C_w1_addr", obs_a(n0 + 1), 32'h0000);
        check("C_w1_data", obs_d(n0 + 1), 32'h56);

        // LEN = 0 means 256 bytes.
        n0 = obs_addr.size();
        send_packet("D", 8'h02, 16'h0200, 8'h00, 8'h00, 1'b0, -1, -1, 1'b0);
        check("D_count", obs_addr.size() - n0, 32'd256);
        check("D_last_addr", obs_a(n0 + 255), 32'h02FF);
        check("D_last_data", obs_d(n0 + 255), 32'hFF);

        // Two-cycle low glitch on an idle line.
        n0 = obs_addr.size();
        $display("glitch 2 cycles");
        ftdi_rx = 1'b0;
        repeat (2) @(negedge clk);
        ftdi_rx = 1'b1;
        idle_bits(3);
        check("glitch_err", {31'h0, err}, 32'h0);
        check("glitch_busy", {31'h0, busy}, 32'h0);
        check("glitch_writes", obs_addr.size() - n0, 32'h0);

        // Framing error on the 2nd data byte.
        n0 = obs_addr.size();
        send_packet("E", 8'h01, 16'h0100, 8'h03, 8'h10, 1'b0, 1, -1, 1'b1);
        check("E_count", obs_addr.size() - n0, 32'd1);
        check("E_w0_addr", obs_a(n0), 32'h0100);

        // Stall after ADDR_LO.
        $display("packet F stall after ADDR_LO");
        send_byte(8'hA5, 1'b1);
        check("F_a5_err", {31'h0, err}, 32'h0);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h20, 1'b1);
        check("F_busy_before", {31'h0, busy}, 32'h1);
        idle_bits(25);
        check("F_timeout_err", {31'h0, err}, 32'h1);
        check("F_timeout_busy", {31'h0, busy}, 32'h0);

        // rst in the middle of the data phase.
        n0 = obs_addr.size();
        send_packet("G", 8'h01, 16'h0300, 8'h05, 8'h30, 1'b0, -1, 2, 1'b0);
        check("G_count", obs_addr.size() - n0, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
